fetch_issue_unit: RTL and testbench
===================================

Name: fetch_issue_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder/controller.
- Holds the PC and fetches 32-bit instructions from instruction memory over a variable-latency request/valid handshake.
- Presents the latched instruction and its op/func fields to the controller, then waits for the execute stage to finish.
- Computes the next PC from the controller's branch/jump/return outputs plus the ALU zero flag.

Parameters:
PC_W, 8, PC and instruction-memory word-address width (word-addressed; PC increments by 1).
RESET_PC, 0, PC value loaded on reset.
TIMEOUT, 16, maximum number of WAIT_MEM cycles without imem_rvalid before a fetch fault.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request, one-cycle pulse.
imem_addr  out  PC_W  fetch address; equals pc.
imem_rvalid  in  1  instruction data valid.
imem_rdata  in  32  instruction word.
instr_valid  out  1  instr/op/func are valid for the controller.
instr  out  32  latched instruction register.
op  out  6  instr[31:26].
func  out  6  instr[5:0].
pc  out  PC_W  address of the current instruction.
pc_link  out  PC_W  pc+1 (mod 2^PC_W); link value written by JAL.
ex_done  in  1  execute stage has completed the current instruction.
branch  in  1  controller branch.
beq_ben  in  1  0 = BEQ, 1 = BNE.
alu_zero  in  1  ALU equality/zero flag.
jump  in  1  controller mux_PC_JType.
ret  in  1  controller mux_RET.
ret_addr  in  PC_W  return address from the register file.
fetch_err  out  1  sticky fetch-timeout fault.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH, pc=RESET_PC, instr=0, wait counter=0.
  - Outputs: imem_req=0, instr_valid=0, fetch_err=0, op=0, func=0.
  - Reset asserted mid-operation aborts any outstanding fetch; an imem_rvalid arriving afterwards is ignored unless the unit is in WAIT_MEM.
- States:
  - FETCH:
    - imem_req=1 and imem_addr=pc for exactly this cycle (Moore output).
    - Go to WAIT_MEM; clear counter.
  - WAIT_MEM:
    - imem_req=0.
    - If imem_rvalid: instr<=imem_rdata, go to ISSUE. imem_rvalid takes priority over timeout.
    - Else if counter==TIMEOUT-1: go to HALT.
    - Else counter++.
    - imem_rvalid is sampled only in this state; the earliest accept is the cycle after imem_req.
  - ISSUE:
    - instr_valid=1; instr/op/func/pc stable.
    - ex_done may be asserted on the first ISSUE cycle.
    - On ex_done: pc<=next_pc, go to FETCH.
    - Without ex_done: hold indefinitely.
  - HALT:
    - fetch_err=1, instr_valid=0, imem_req=0.
    - Exit only via reset.
- next_pc, evaluated in ISSUE on ex_done. Priority order:
  1. ret=1 -> ret_addr.
  2. jump=1 -> instr[25:0] truncated to PC_W bits.
  3. branch=1 and (alu_zero XOR beq_ben)=1 -> pc+1+sign_extend(instr[15:0]), truncated to PC_W.
  4. Otherwise pc+1.
  - All arithmetic wraps modulo 2^PC_W.
  - Control inputs with X/Z values are not sampled outside the ex_done cycle.
- Latency:
  - Zero-wait memory: 3 cycles per instruction (FETCH, WAIT_MEM, ISSUE with immediate ex_done).
  - Each extra memory-wait cycle adds 1 cycle.
- op/func/pc_link are combinational from instr/pc; they are 0-valued fields while instr=0.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, imem_rvalid tied 1 with rdata=0x00000020, ex_done tied 1.
  - Required: imem_req pulses at cycles 1,4,7 with imem_addr 0,1,2; instr_valid high at cycles 3,6,9; func=0x20.
- Memory wait and timeout:
  - Stimulus A: rvalid asserted after 15 WAIT_MEM cycles (TIMEOUT=16).
  - Required A: instruction accepted, no fault.
  - Stimulus B: rvalid never asserted.
  - Required B: fetch_err=1 after 16 WAIT_MEM cycles; no further imem_req; only rst_n clears it.
- Branch:
  - Stimulus: pc=0x10, instr[15:0]=0xFFFC, branch=1, beq_ben=0, alu_zero=1.
  - Required: next imem_addr=0x0D.
  - Same with alu_zero=0: imem_addr=0x11.
  - BNE (beq_ben=1) with alu_zero=0: imem_addr=0x0D.
- Jump/return priority and wrap:
  - Stimulus 1: jump=1, instr[25:0]=0x1A5. Required: imem_addr=0xA5.
  - Stimulus 2: ret=1 and jump=1, ret_addr=0x33. Required: imem_addr=0x33.
  - Stimulus 3: pc=0xFF with no redirect. Required: imem_addr=0x00, and pc_link=0x00 during that ISSUE.
- Stall in ISSUE:
  - Stimulus: hold ex_done=0 for 5 cycles.
  - Required: instr_valid stays 1; instr and pc unchanged; no imem_req.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during WAIT_MEM, then release; a late imem_rvalid arrives after reset.
  - Required: outputs go to reset values immediately; first imem_req after release uses imem_addr=RESET_PC; the late rvalid is not latched.

Source files
------------

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: instruction-fetch stage ahead of the decoder/controller.
// Fetches one word per instruction over a req/rvalid handshake, presents it
// to the controller, waits for execute to finish, then steps the PC.
module fetch_issue_unit #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [5:0]      op,
   output logic [5:0]      func,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_link,
   input  logic            ex_done,
   input  logic            branch,
   input  logic            beq_ben,
   input  logic            alu_zero,
   input  logic            jump,
   input  logic            ret,
   input  logic [PC_W-1:0] ret_addr,
   output logic            fetch_err
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_FETCH    = 2'd0;
   localparam logic [1:0] ST_WAIT_MEM = 2'd1;
   localparam logic [1:0] ST_ISSUE    = 2'd2;
   localparam logic [1:0] ST_HALT     = 2'd3;

   logic [1:0]      state;
   logic [CNT_W-1:0] wait_cnt;
   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] jmp_tgt;
   logic [PC_W-1:0] next_pc;
   logic            br_taken;

   // Branch offset is the sign-extended 16-bit immediate reduced to PC width;
   // the jump target is the 26-bit field zero-extended or truncated likewise.
   generate
      if (PC_W <= 16) begin : g_off_narrow
         assign br_off = instr[PC_W-1:0];
      end else begin : g_off_wide
         assign br_off = {{(PC_W-16){instr[15]}}, instr[15:0]};
      end
      if (PC_W <= 26) begin : g_jmp_narrow
         assign jmp_tgt = instr[PC_W-1:0];
      end else begin : g_jmp_wide
         assign jmp_tgt = {{(PC_W-26){1'b0}}, instr[25:0]};
      end
   endgenerate

   assign pc_link  = pc + PC_W'(1);
   assign br_taken = branch & (alu_zero ^ beq_ben);

   // Next-PC selection: return beats jump beats taken branch beats fall-through.
   always_comb begin
      next_pc = pc_link;
      if (ret) begin
         next_pc = ret_addr;
      end else if (jump) begin
         next_pc = jmp_tgt;
      end else if (br_taken) begin
         next_pc = pc_link + br_off;
      end
   end

   // Fetch/issue sequencer with the memory-wait timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_FETCH;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_FETCH: begin
               state    <= ST_WAIT_MEM;
               wait_cnt <= '0;
            end
            ST_WAIT_MEM: begin
               if (imem_rvalid) begin
                  state <= ST_ISSUE;
               end else if (wait_cnt == CNT_LAST) begin
                  state <= ST_HALT;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ST_ISSUE: begin
               if (ex_done) begin
                  state <= ST_FETCH;
               end
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

   // PC advances only when execute retires the issued instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (state == ST_ISSUE && ex_done) begin
         pc <= next_pc;
      end
   end

   // Instruction register captures memory data only while waiting for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= '0;
      end else if (state == ST_WAIT_MEM && imem_rvalid) begin
         instr <= imem_rdata;
      end
   end

   // Request is gated by rst_n so it is low for the whole reset interval
   // even though the sequencer sits in FETCH during reset.
   assign imem_req    = rst_n & (state == ST_FETCH);
   assign imem_addr   = pc;
   assign instr_valid = (state == ST_ISSUE);
   assign fetch_err   = (state == ST_HALT);
   assign op          = instr[31:26];
   assign func        = instr[5:0];

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: directed and randomized checks of fetch_issue_unit
// against a PC model computed from the instruction-flow rules.
module tb_fetch_issue_unit;

   localparam int         PC_W     = 8;
   localparam logic [7:0] RESET_PC = 8'h00;
   localparam int         TIMEOUT  = 16;
   localparam int         PC_MOD   = 1 << PC_W;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;
   logic            instr_valid;
   logic [31:0]     instr;
   logic [5:0]      op;
   logic [5:0]      func;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_link;
   logic            ex_done;
   logic            branch;
   logic            beq_ben;
   logic            alu_zero;
   logic            jump;
   logic            ret;
   logic [PC_W-1:0] ret_addr;
   logic            fetch_err;

   int nchk  = 0;
   int nfail = 0;
   int exp_pc;

   fetch_issue_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr(instr), .op(op), .func(func), .pc(pc), .pc_link(pc_link),
      .ex_done(ex_done), .branch(branch), .beq_ben(beq_ben), .alu_zero(alu_zero),
      .jump(jump), .ret(ret), .ret_addr(ret_addr), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference next-PC from the instruction-flow rules, in plain integer arithmetic.
   function automatic int model_next(input int cur, input logic [31:0] w, input bit br,
                                     input bit bne, input bit z, input bit jmp,
                                     input bit rt, input int raddr);
      int off;
      if (rt) return raddr % PC_MOD;
      if (jmp) return int'(w[25:0]) % PC_MOD;
      if (br && (z != bne)) begin
         off = 32'(w[15:0]);
         if (off >= 32768) off = off - 65536;
         return (cur + 1 + off) & (PC_MOD - 1);
      end
      return (cur + 1) % PC_MOD;
   endfunction

   task automatic rand_ctrl();
      branch   = 1'($urandom);
      beq_ben  = 1'($urandom);
      alu_zero = 1'($urandom);
      jump     = 1'($urandom);
      ret      = 1'($urandom);
      ret_addr = PC_W'($urandom);
   endtask

   // One full instruction: fetch, wt extra memory waits, stall cycles in
   // ISSUE, then retire with the given controls. forced >= 0 overrides the
   // model with a literal expected next address.
   task automatic do_instr(input logic [31:0] w, input int wt, input int stall,
                           input bit br, input bit bne, input bit z, input bit jmp,
                           input bit rt, input logic [7:0] raddr, input int forced);
      for (int k = 0; k < 4 && imem_req !== 1'b1; k++) @(negedge clk);
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", 32'(imem_addr), 32'(exp_pc));
      check("fetch_ivalid", 32'(instr_valid), 32'd0);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      @(negedge clk);
      for (int i = 0; i <= wt; i++) begin
         check("wait_req", 32'(imem_req), 32'd0);
         check("wait_ivalid", 32'(instr_valid), 32'd0);
         check("wait_err", 32'(fetch_err), 32'd0);
         imem_rvalid = (i == wt);
         imem_rdata  = (i == wt) ? w : $urandom;
         @(negedge clk);
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      check("issue_ivalid", 32'(instr_valid), 32'd1);
      check("issue_instr", instr, w);
      check("issue_op", 32'(op), 32'(w[31:26]));
      check("issue_func", 32'(func), 32'(w[5:0]));
      check("issue_pc", 32'(pc), 32'(exp_pc));
      check("issue_pc_link", 32'(pc_link), 32'((exp_pc + 1) % PC_MOD));
      check("issue_err", 32'(fetch_err), 32'd0);
      for (int s = 0; s < stall; s++) begin
         ex_done = 1'b0;
         rand_ctrl();
         @(negedge clk);
         check("stall_ivalid", 32'(instr_valid), 32'd1);
         check("stall_instr", instr, w);
         check("stall_pc", 32'(pc), 32'(exp_pc));
         check("stall_req", 32'(imem_req), 32'd0);
      end
      ex_done  = 1'b1;
      branch   = br;
      beq_ben  = bne;
      alu_zero = z;
      jump     = jmp;
      ret      = rt;
      ret_addr = raddr;
      @(negedge clk);
      ex_done = 1'b0;
      rand_ctrl();
      exp_pc = (forced >= 0) ? forced : model_next(exp_pc, w, br, bne, z, jmp, rt, int'(raddr));
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0020;
      ex_done     = 1'b1;
      branch      = 1'b0;
      beq_ben     = 1'b0;
      alu_zero    = 1'b0;
      jump        = 1'b0;
      ret         = 1'b0;
      ret_addr    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_ivalid", 32'(instr_valid), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);
      check("rst_pc", 32'(pc), 32'(RESET_PC));
      check("rst_instr", instr, 32'd0);
      check("rst_op", 32'(op), 32'd0);
      check("rst_func", 32'(func), 32'd0);

      // Sequential fetch with zero-wait memory and immediate ex_done.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         check("seq_req", 32'(imem_req), 32'((cyc % 3) == 1));
         check("seq_ivalid", 32'(instr_valid), 32'((cyc % 3) == 0));
         if ((cyc % 3) == 1) check("seq_addr", 32'(imem_addr), 32'((int'(RESET_PC) + (cyc - 1) / 3) % PC_MOD));
         if ((cyc % 3) == 0) check("seq_func", 32'(func), 32'h20);
         @(negedge clk);
         #1;
      end
      ex_done     = 1'b0;
      imem_rvalid = 1'b0;
      exp_pc      = (int'(RESET_PC) + 3) % PC_MOD;

      // Longest wait that still succeeds, jumping to 0x10.
      do_instr(32'h0800_0010, TIMEOUT - 1, 0, 0, 0, 0, 1, 0, 8'h00, -1);
      // Branches from pc 0x10 with offset -4.
      do_instr(32'h1000_FFFC, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h0D);
      do_instr(32'h0800_0010, 1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h10);
      do_instr(32'h1000_FFFC, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h11);
      do_instr(32'h0800_0010, 2, 0, 0, 0, 0, 1, 0, 8'h00, 8'h10);
      do_instr(32'h1400_FFFC, 0, 0, 1, 1, 0, 0, 0, 8'h00, 8'h0D);
      // Jump truncation, return priority, wrap with a 5-cycle stall.
      do_instr(32'h0800_01A5, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'hA5);
      do_instr(32'h0C00_00AB, 0, 0, 0, 0, 0, 1, 1, 8'h33, 8'h33);
      do_instr(32'h0800_00FF, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'hFF);
      do_instr(32'h0022_1820, 0, 5, 0, 0, 0, 0, 0, 8'h00, 8'h00);

      // Randomized instruction stream against the model.
      for (int n = 0; n < 40; n++) begin
         do_instr($urandom, $urandom_range(0, 4), $urandom_range(0, 2),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  8'($urandom), -1);
      end
      do_instr(32'h0800_005A, 0, 0, 0, 0, 0, 1, 0, 8'h00, -1);

      // Reset during WAIT_MEM, late rvalid, then a fetch that times out.
      for (int k = 0; k < 4 && imem_req !== 1'b1; k++) @(negedge clk);
      check("mid_fetch_addr", 32'(imem_addr), 32'h5A);
      imem_rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_req", 32'(imem_req), 32'd0);
      check("mid_rst_ivalid", 32'(instr_valid), 32'd0);
      check("mid_rst_pc", 32'(pc), 32'(RESET_PC));
      check("mid_rst_instr", instr, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_req", 32'(imem_req), 32'd1);
      check("post_rst_addr", 32'(imem_addr), 32'(RESET_PC));
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("late_rvalid_instr", instr, 32'd0);
      check("late_rvalid_ivalid", 32'(instr_valid), 32'd0);
      for (int i = 1; i < TIMEOUT; i++) begin
         @(negedge clk);
         check("to_wait_err", 32'(fetch_err), 32'd0);
         check("to_wait_req", 32'(imem_req), 32'd0);
      end
      @(negedge clk);
      check("to_err", 32'(fetch_err), 32'd1);
      check("to_ivalid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 5; i++) begin
         imem_rvalid = 1'($urandom);
         ex_done     = 1'($urandom);
         @(negedge clk);
         check("halt_err", 32'(fetch_err), 32'd1);
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_ivalid", 32'(instr_valid), 32'd0);
      end
      imem_rvalid = 1'b0;
      ex_done     = 1'b0;
      rst_n       = 1'b0;
      #1;
      check("halt_rst_err", 32'(fetch_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("halt_rst_req", 32'(imem_req), 32'd1);
      check("halt_rst_addr", 32'(imem_addr), 32'(RESET_PC));

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
